// File: rtl/dcg_pkg.sv
// Shared types and defaults for the duty-cycle clock generator.
package dcg_pkg;

    localparam int unsigned DCG_CNT_WIDTH   = 8;
    localparam int unsigned DCG_LOCK_CYCLES = 4;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        HIGH,
        LOW
    } dcg_state_t;

    // A period needs at least one high and one low cycle.
    function automatic logic cfg_valid(input logic [31:0] high, input logic [31:0] low);
        return (high != '0) && (low != '0);
    endfunction

endpackage

// File: rtl/dcg_phase_counter.sv
// Loadable down-counter timing the DELAY, HIGH and LOW phases.
module dcg_phase_counter
    import dcg_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = DCG_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] load_value,
    output logic [CNT_WIDTH-1:0] value,
    output logic                 tc
);

    // Reload on request, otherwise count down and park at zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (value != '0) begin
            value <= value - CNT_WIDTH'(1);
        end
    end

    assign tc = (value == '0);

endmodule

// File: rtl/duty_cycle_gen.sv
// Counter-based clock generator with programmable high, low and start phase.
module duty_cycle_gen
    import dcg_pkg::*;
#(
    parameter int unsigned CNT_WIDTH   = DCG_CNT_WIDTH,
    parameter int unsigned LOCK_CYCLES = DCG_LOCK_CYCLES
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [CNT_WIDTH-1:0] high_count,
    input  logic [CNT_WIDTH-1:0] low_count,
    input  logic [CNT_WIDTH-1:0] phase_count,
    output logic                 clk_out,
    output logic                 locked,
    output logic                 period_done,
    output logic                 cfg_err
);

    localparam int unsigned          LOCK_W   = $clog2(LOCK_CYCLES + 1);
    localparam logic [LOCK_W-1:0]    LOCK_MAX = LOCK_W'(LOCK_CYCLES);
    localparam logic [CNT_WIDTH-1:0] ONE      = CNT_WIDTH'(1);

    dcg_state_t           state;
    logic [CNT_WIDTH-1:0] high_s;
    logic [CNT_WIDTH-1:0] low_s;
    logic [LOCK_W-1:0]    lock_cnt;
    logic [LOCK_W-1:0]    lock_nxt;

    logic                 cfg_ok;
    logic                 cfg_changed;
    logic                 cnt_load;
    logic [CNT_WIDTH-1:0] cnt_value;
    logic [CNT_WIDTH-1:0] cnt_cur;
    logic                 cnt_tc;

    dcg_phase_counter #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_phase_counter (
        .clk       (clk),
        .reset     (reset),
        .load      (cnt_load),
        .load_value(cnt_value),
        .value     (cnt_cur),
        .tc        (cnt_tc)
    );

    // Counter reload selection and saturating lock increment
    always_comb begin
        cfg_ok      = cfg_valid(32'(high_count), 32'(low_count));
        cfg_changed = (high_count != high_s) || (low_count != low_s);
        lock_nxt    = (lock_cnt == LOCK_MAX) ? lock_cnt : lock_cnt + LOCK_W'(1);
        cnt_load    = 1'b0;
        cnt_value   = '0;
        unique case (state)
            IDLE: begin
                if (enable && cfg_ok) begin
                    cnt_load  = 1'b1;
                    cnt_value = (phase_count != '0) ? phase_count - ONE : high_count - ONE;
                end
            end
            DELAY: begin
                if (cnt_tc) begin
                    cnt_load  = 1'b1;
                    cnt_value = high_s - ONE;
                end
            end
            HIGH: begin
                if (cnt_tc) begin
                    cnt_load  = 1'b1;
                    cnt_value = low_s - ONE;
                end
            end
            LOW: begin
                // Live high_count equals high_s when config is unchanged
                if (cnt_tc && enable && cfg_ok) begin
                    cnt_load  = 1'b1;
                    cnt_value = high_count - ONE;
                end
            end
            default: ;
        endcase
    end

    // Phase FSM, shadow config, lock tracking and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            high_s      <= '0;
            low_s       <= '0;
            lock_cnt    <= '0;
            clk_out     <= 1'b0;
            locked      <= 1'b0;
            period_done <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            // Outputs follow the state one cycle later, keeping them glitch-free
            clk_out     <= (state == HIGH);
            period_done <= (state == LOW) && cnt_tc;
            unique case (state)
                IDLE: begin
                    if (enable) begin
                        if (!cfg_ok) begin
                            cfg_err <= 1'b1;
                        end else begin
                            high_s   <= high_count;
                            low_s    <= low_count;
                            cfg_err  <= 1'b0;
                            lock_cnt <= '0;
                            state    <= (phase_count != '0) ? DELAY : HIGH;
                        end
                    end
                end
                DELAY: begin
                    if (cnt_tc) state <= HIGH;
                end
                HIGH: begin
                    if (cnt_tc) state <= LOW;
                end
                LOW: begin
                    if (cnt_tc) begin
                        if (!enable) begin
                            state <= IDLE;
                        end else if (!cfg_ok) begin
                            cfg_err  <= 1'b1;
                            locked   <= 1'b0;
                            lock_cnt <= '0;
                            state    <= IDLE;
                        end else if (cfg_changed) begin
                            high_s   <= high_count;
                            low_s    <= low_count;
                            lock_cnt <= '0;
                            locked   <= 1'b0;
                            state    <= HIGH;
                        end else begin
                            lock_cnt <= lock_nxt;
                            locked   <= (lock_nxt == LOCK_MAX);
                            state    <= HIGH;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
            // Losing enable unlocks at once, while the period still runs out
            if (!enable) begin
                locked   <= 1'b0;
                lock_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_duty_cycle_gen.sv
// Scoreboard bench for duty_cycle_gen: expected per-cycle output vectors
// {clk_out, period_done, locked, cfg_err} are queued as stimulus is applied.
module tb_duty_cycle_gen;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [7:0] high_count;
    logic [7:0] low_count;
    logic [7:0] phase_count;
    logic       clk_out;
    logic       locked;
    logic       period_done;
    logic       cfg_err;

    int         checks;
    int         errors;
    logic [3:0] sb[$];

    duty_cycle_gen #(
        .CNT_WIDTH  (8),
        .LOCK_CYCLES(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .high_count (high_count),
        .low_count  (low_count),
        .phase_count(phase_count),
        .clk_out    (clk_out),
        .locked     (locked),
        .period_done(period_done),
        .cfg_err    (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_n(input int unsigned n, input logic [3:0] e);
        for (int unsigned i = 0; i < n; i++) sb.push_back(e);
    endtask

    // One period: h high samples, l low samples, pulse on the last low sample
    task automatic push_period(input int unsigned h, input int unsigned l,
                               input logic lk_in, input logic lk_end);
        push_n(h, {1'b1, 1'b0, lk_in, 1'b0});
        push_n(l - 1, {1'b0, 1'b0, lk_in, 1'b0});
        sb.push_back({1'b0, 1'b1, lk_end, 1'b0});
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        enable = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] act;
        @(posedge clk);
        #1;
        act = {clk_out, period_done, locked, cfg_err};
        checks++;
        if (act !== 4'b0000) begin
            errors++;
            $display("FAIL reset_state got %b want 0000", act);
        end
        reset       = 1'b0;
        high_count  = 8'd5;
        low_count   = 8'd5;
        phase_count = 8'd0;
        enable      = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (clk_out !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_high got %b want 1", clk_out);
        end
        #2;
        reset = 1'b1;
        #1;
        act = {clk_out, period_done, locked, cfg_err};
        checks++;
        if (act !== 4'b0000) begin
            errors++;
            $display("FAIL reset_async_high got %b want 0000", act);
        end
    endtask

    task automatic test_basic();
        int         n;
        logic [3:0] exp;
        logic [3:0] act;
        do_reset();
        high_count  = 8'd5;
        low_count   = 8'd5;
        phase_count = 8'd0;
        enable      = 1'b1;
        push_n(1, 4'b0000);
        for (int k = 1; k <= 6; k++) push_period(5, 5, k >= 5, k >= 4);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            exp = sb.pop_front();
            act = {clk_out, period_done, locked, cfg_err};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL basic_5_5 sample %0d got %b want %b", i, act, exp);
            end
        end
    endtask

    task automatic test_phase();
        int         n;
        int         highs;
        logic [3:0] exp;
        logic [3:0] act;
        do_reset();
        high_count  = 8'd3;
        low_count   = 8'd7;
        phase_count = 8'd4;
        enable      = 1'b1;
        highs       = 0;
        push_n(5, 4'b0000);
        for (int k = 1; k <= 5; k++) push_period(3, 7, k >= 5, k >= 4);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (i >= 45 && i <= 54 && clk_out === 1'b1 && locked === 1'b1) highs++;
            exp = sb.pop_front();
            act = {clk_out, period_done, locked, cfg_err};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL phase_3_7 sample %0d got %b want %b", i, act, exp);
            end
        end
        checks++;
        if (highs !== 3) begin
            errors++;
            $display("FAIL duty_30pct high_cycles got %0d want 3", highs);
        end
    endtask

    task automatic test_cfg_err();
        int         n;
        logic [3:0] exp;
        logic [3:0] act;
        do_reset();
        high_count  = 8'd0;
        low_count   = 8'd5;
        phase_count = 8'd0;
        enable      = 1'b1;
        push_n(6, 4'b0001);
        push_n(1, 4'b0000);
        for (int k = 1; k <= 2; k++) push_period(2, 5, 1'b0, 1'b0);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            exp = sb.pop_front();
            act = {clk_out, period_done, locked, cfg_err};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL cfg_err sample %0d got %b want %b", i, act, exp);
            end
            if (i == 5) high_count = 8'd2;
        end
    endtask

    task automatic test_reconfig();
        int         n;
        logic [3:0] exp;
        logic [3:0] act;
        do_reset();
        high_count  = 8'd5;
        low_count   = 8'd5;
        phase_count = 8'd0;
        enable      = 1'b1;
        push_n(1, 4'b0000);
        for (int k = 1; k <= 4; k++) push_period(5, 5, 1'b0, k >= 4);
        push_period(5, 5, 1'b1, 1'b0);
        for (int k = 1; k <= 5; k++) push_period(2, 8, k >= 5, k >= 4);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            exp = sb.pop_front();
            act = {clk_out, period_done, locked, cfg_err};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL reconfig sample %0d got %b want %b", i, act, exp);
            end
            if (i == 42) begin
                high_count = 8'd2;
                low_count  = 8'd8;
            end
        end
    endtask

    task automatic test_graceful_stop();
        int         n;
        logic [3:0] exp;
        logic [3:0] act;
        do_reset();
        high_count  = 8'd6;
        low_count   = 8'd6;
        phase_count = 8'd0;
        enable      = 1'b1;
        push_n(1, 4'b0000);
        for (int k = 1; k <= 4; k++) push_period(6, 6, 1'b0, k >= 4);
        push_n(2, 4'b1010);
        push_n(4, 4'b1000);
        push_n(5, 4'b0000);
        push_n(1, 4'b0100);
        push_n(10, 4'b0000);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            exp = sb.pop_front();
            act = {clk_out, period_done, locked, cfg_err};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL graceful_stop sample %0d got %b want %b", i, act, exp);
            end
            if (i == 50) enable = 1'b0;
        end
    endtask

    task automatic test_max_reset();
        int         n;
        int         highs;
        logic [3:0] exp;
        logic [3:0] act;
        do_reset();
        high_count  = 8'd255;
        low_count   = 8'd255;
        phase_count = 8'd0;
        enable      = 1'b1;
        push_n(1, 4'b0000);
        push_n(255, 4'b1000);
        push_n(45, 4'b0000);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            exp = sb.pop_front();
            act = {clk_out, period_done, locked, cfg_err};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL max_pre_reset sample %0d got %b want %b", i, act, exp);
            end
        end
        #2;
        reset = 1'b1;
        #1;
        act = {clk_out, period_done, locked, cfg_err};
        checks++;
        if (act !== 4'b0000) begin
            errors++;
            $display("FAIL reset_async_low got %b want 0000", act);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        highs = 0;
        push_n(1, 4'b0000);
        push_period(255, 255, 1'b0, 1'b0);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (clk_out === 1'b1) highs++;
            exp = sb.pop_front();
            act = {clk_out, period_done, locked, cfg_err};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL max_post_reset sample %0d got %b want %b", i, act, exp);
            end
        end
        checks++;
        if (highs !== 255) begin
            errors++;
            $display("FAIL max_high_cycles got %0d want 255", highs);
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        reset       = 1'b1;
        enable      = 1'b0;
        high_count  = '0;
        low_count   = '0;
        phase_count = '0;
        test_reset();
        test_basic();
        test_phase();
        test_cfg_err();
        test_reconfig();
        test_graceful_stop();
        test_max_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
